match_control_fsm: RTL
======================

Name: match_control_fsm

Overview:
- Upstream controller that generates the game_on qualifier consumed by the game-logic top level.
- Debounces the raw start/pause pushbutton and sequences the match through these phases: idle, serve delay, play, pause, point hold, match over.
- Freezes play for a fixed serve delay after every point, and latches end-of-match when either score total reaches the winning score.

Parameters:
- DEBOUNCE_CYCLES, 1000000: clocks the synchronized button must be stable before a level change is accepted (20 ms at 50 MHz).
- SERVE_CYCLES, 50000000: clocks game_on is held low in SERVE before play resumes (1 s at 50 MHz).
- WIN_SCORE, 7: total at or above which the match ends.

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset, input, 1: asynchronous, active-high reset.
- start_btn_n, input, 1: raw pushbutton, active-low, asynchronous to clk.
- point1, input, 1: one-cycle pulse, player 1 scored.
- point2, input, 1: one-cycle pulse, player 2 scored.
- p1_total, input, 3: player 1 running score.
- p2_total, input, 3: player 2 running score.
- game_on, output, 1: high only in PLAY; ball and paddles advance only when high.
- serve_dir, output, 1: 0 = serve toward player 1, 1 = serve toward player 2.
- match_over, output, 1: high while in OVER.
- new_match, output, 1: one-cycle pulse on OVER->IDLE; downstream clears scores.
- state_code, output, 3: current state encoding, for debug LEDs.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - game_on = 0, serve_dir = 0, match_over = 0, new_match = 0, state_code = 0.
  - Counters = 0.
  - Synchronizer flops = 1 (button released); debounced level = released.
- Button path:
  - 2-flop synchronizer on start_btn_n.
  - Debounce counter resets whenever the synchronized value equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value and the counter clears.
  - press = one-cycle pulse on a debounced released->pressed transition. Release produces no pulse.
  - Latency from the raw edge to press is 2 + DEBOUNCE_CYCLES clocks. Glitches shorter than DEBOUNCE_CYCLES produce no press.
- States (state_code value):
  - IDLE (0): press -> SERVE, serve counter loaded 0.
  - SERVE (1): serve counter increments each clock; at SERVE_CYCLES-1 -> PLAY. A press in SERVE is ignored.
  - PLAY (2):
    - point1 -> POINT with serve_dir <= 1.
    - else point2 -> POINT with serve_dir <= 0.
    - else press -> PAUSED.
    - Priority: point1 > point2 > press.
  - PAUSED (3): press -> PLAY; the serve counter is not used.
  - POINT (4): single-cycle hold that lets the score block update its totals. Next cycle:
    - (p1_total >= WIN_SCORE) or (p2_total >= WIN_SCORE) -> OVER;
    - else -> SERVE with the counter cleared.
  - OVER (5): match_over = 1; press -> IDLE, with new_match high for exactly the first IDLE cycle.
  - Encodings 6 and 7 are unreachable and recover to IDLE on the next clock.
- Outputs are registered:
  - game_on = (next state == PLAY), registered, so it is high in the same cycle state_code reads 2.
  - match_over is likewise high in the same cycle state_code reads 5.
- point1/point2 outside PLAY are ignored, with no state or serve_dir change.
- serve_dir changes only on the PLAY->POINT transition.
- Totals comparison is 3-bit unsigned against WIN_SCORE, truncated to 3 bits.
- Reset asserted mid-operation (any state, mid-debounce, mid-serve) returns everything to the reset values immediately. No press is generated when reset deasserts while the button is held; the button must be released and pressed again.

Test Plan (DEBOUNCE_CYCLES=4, SERVE_CYCLES=10, WIN_SCORE=7):
1. Reset, then hold start_btn_n low for 8 clocks -> exactly one press; state 0->1. After 10 more clocks state=2 and game_on=1. No second press while held.
2. 3-clock low glitch on start_btn_n in IDLE -> no press; state stays 0; game_on stays 0.
3. In PLAY, debounced press -> state 3, game_on=0. Second press -> state 2, game_on=1. A point1 pulse while in PAUSED -> ignored.
4. In PLAY, point1 and point2 in the same cycle with totals 2/1 -> POINT, serve_dir=1, then SERVE. game_on stays low 10 clocks, then PLAY.
5. In PLAY, point2 pulse, then p2_total driven to 7 before the POINT check -> state 5, match_over=1, game_on=0. A press -> state 0, new_match high for 1 cycle, match_over=0.
6. Assert reset during SERVE at serve count 5 -> state 0 and all outputs at reset values the same cycle. Release reset with the button held low -> no press until released and pressed again.

Source files
------------

// File: rtl/match_control_if.sv
// Signal bundle between the match controller and the surrounding game logic.
// The master side drives the button, point pulses and score totals; the slave side is the controller.
interface match_control_if;
  logic       start_btn_n;
  logic       point1;
  logic       point2;
  logic [2:0] p1_total;
  logic [2:0] p2_total;
  logic       game_on;
  logic       serve_dir;
  logic       match_over;
  logic       new_match;
  logic [2:0] state_code;

  modport master (
    output start_btn_n, point1, point2, p1_total, p2_total,
    input  game_on, serve_dir, match_over, new_match, state_code
  );

  modport slave (
    input  start_btn_n, point1, point2, p1_total, p2_total,
    output game_on, serve_dir, match_over, new_match, state_code
  );
endinterface

// File: rtl/match_control_fsm.sv
// Match sequencer: debounces the start/pause button and walks the match through
// idle, serve delay, play, pause, point hold and match over, producing the game_on qualifier.
module match_control_fsm #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SERVE_CYCLES    = 50000000,
  parameter int WIN_SCORE       = 7
) (
  input logic            clk,
  input logic            reset,
  match_control_if.slave mc
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_POINT  = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SRV_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [SRV_W-1:0] SRV_LAST  = SRV_W'(SERVE_CYCLES - 1);
  localparam logic [SRV_W-1:0] SRV_ONE   = SRV_W'(1);
  localparam logic [2:0]       WIN_TOTAL = 3'(WIN_SCORE);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_level_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic             press_r;
  logic [1:0]       post_rst_r;
  logic             armed_r;
  state_t           state_r;
  state_t           state_next_s;
  logic [SRV_W-1:0] serve_cnt_r;
  logic             serve_dir_r;
  logic             serve_dir_next_s;
  logic             game_on_r;
  logic             match_over_r;
  logic             new_match_r;
  logic             win_s;

  // Synchronize and debounce the button; press fires on a debounced release->pressed change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r     <= 1'b1;
      sync2_r     <= 1'b1;
      deb_level_r <= 1'b1;
      deb_cnt_r   <= '0;
      press_r     <= 1'b0;
    end else begin
      sync1_r <= mc.start_btn_n;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == deb_level_r) begin
        deb_cnt_r <= '0;
      end else if (deb_cnt_r == DEB_LAST) begin
        deb_level_r <= sync2_r;
        deb_cnt_r   <= '0;
        press_r     <= armed_r & ~sync2_r;
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_ONE;
      end
    end
  end

  // A button held through reset must be seen released (debounced) before it can press.
  // The synchronizer only reflects the real pin from the third clock after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      post_rst_r <= 2'd0;
      armed_r    <= 1'b0;
    end else begin
      post_rst_r <= (post_rst_r == 2'd2) ? 2'd2 : post_rst_r + 2'd1;
      if ((post_rst_r == 2'd2) && sync2_r && deb_level_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign win_s = (mc.p1_total >= WIN_TOTAL) || (mc.p2_total >= WIN_TOTAL);

  // Next-state and serve direction decode.
  always_comb begin
    state_next_s     = state_r;
    serve_dir_next_s = serve_dir_r;
    case (state_r)
      ST_IDLE: begin
        if (press_r) state_next_s = ST_SERVE;
        else         state_next_s = ST_IDLE;
      end
      ST_SERVE: begin
        if (serve_cnt_r == SRV_LAST) state_next_s = ST_PLAY;
        else                         state_next_s = ST_SERVE;
      end
      ST_PLAY: begin
        if (mc.point1) begin
          state_next_s     = ST_POINT;
          serve_dir_next_s = 1'b1;
        end else if (mc.point2) begin
          state_next_s     = ST_POINT;
          serve_dir_next_s = 1'b0;
        end else if (press_r) begin
          state_next_s = ST_PAUSED;
        end else begin
          state_next_s = ST_PLAY;
        end
      end
      ST_PAUSED: begin
        if (press_r) state_next_s = ST_PLAY;
        else         state_next_s = ST_PAUSED;
      end
      ST_POINT: begin
        if (win_s) state_next_s = ST_OVER;
        else       state_next_s = ST_SERVE;
      end
      ST_OVER: begin
        if (press_r) state_next_s = ST_IDLE;
        else         state_next_s = ST_OVER;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, serve counter and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      serve_cnt_r  <= '0;
      serve_dir_r  <= 1'b0;
      game_on_r    <= 1'b0;
      match_over_r <= 1'b0;
      new_match_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      serve_cnt_r  <= ((state_r == ST_SERVE) && (state_next_s == ST_SERVE)) ?
                      serve_cnt_r + SRV_ONE : '0;
      serve_dir_r  <= serve_dir_next_s;
      game_on_r    <= (state_next_s == ST_PLAY);
      match_over_r <= (state_next_s == ST_OVER);
      new_match_r  <= (state_r == ST_OVER) && (state_next_s == ST_IDLE);
    end
  end

  assign mc.game_on    = game_on_r;
  assign mc.serve_dir  = serve_dir_r;
  assign mc.match_over = match_over_r;
  assign mc.new_match  = new_match_r;
  assign mc.state_code = state_r;

endmodule
